skew_align: RTL and testbench

//  Read-side re-aligner for two signed sample streams that reach it through

---
 rtl/skew_align_pkg.sv | 14 +
 rtl/skew_align_sync_fifo.sv | 75 +++++++
 rtl/skew_align.sv | 137 +++++++++++++
 tb/tb_skew_align.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skew_align_pkg.sv
// Shared definitions for the skew_align re-aligner.
//   SA_DW    : sample width (signed two's complement)
//   SA_DEPTH : per-stream buffer entries (power of 2, >= 2)
//   SA_AW    : pointer width, log2(SA_DEPTH)
//   sample_t : one signed sample
package skew_align_pkg;

    localparam int unsigned SA_DW    = 25;
    localparam int unsigned SA_DEPTH = 8;
    localparam int unsigned SA_AW    = $clog2(SA_DEPTH);

    typedef logic signed [SA_DW-1:0] sample_t;

endpackage

// File: rtl/skew_align_sync_fifo.sv
// sync_fifo: single-clock circular buffer holding one sample stream.
// Push/pop are already qualified by the caller; a push on a full buffer is
// only issued together with a pop, so the counter never exceeds DEPTH.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   clr    synchronous flush of pointers and count (priority over push/pop)
//   push   write din at the write pointer
//   pop    advance the read pointer
//   din    sample in
//   dout   sample at the read pointer (combinational)
//   count  occupancy 0..DEPTH
//   full   count == DEPTH
//   empty  count == 0
module sync_fifo
    import skew_align_pkg::*;
#(
    parameter int unsigned DW    = SA_DW,
    parameter int unsigned DEPTH = SA_DEPTH,
    parameter int unsigned AW    = SA_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Read happens before the same-edge write lands, so a full buffer with
    // simultaneous push+pop (wr_ptr == rd_ptr) still returns the oldest entry.
    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/skew_align.sv
// skew_align: re-aligns two signed sample streams arriving with unequal
// latency. Each stream is buffered; once both buffers hold a sample, one
// entry is popped from each and presented as an aligned (a,b) pair.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low
//   clr        synchronous flush of both buffers and ovf
//   a_valid    a_data qualifies this cycle
//   a_data     stream A sample (signed)
//   b_valid    b_data qualifies this cycle
//   b_data     stream B sample (signed)
//   out_valid  one-cycle pulse per aligned pair
//   out_a      aligned A sample (held between pairs)
//   out_b      aligned B sample (held between pairs)
//   skew       registered occupancy(A) - occupancy(B), signed
//   ovf        sticky flag: a sample was dropped on a full buffer
module skew_align
    import skew_align_pkg::*;
#(
    parameter int unsigned DW    = SA_DW,
    parameter int unsigned DEPTH = SA_DEPTH,
    parameter int unsigned AW    = SA_AW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 a_valid,
    input  logic signed [DW-1:0] a_data,
    input  logic                 b_valid,
    input  logic signed [DW-1:0] b_data,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_a,
    output logic signed [DW-1:0] out_b,
    output logic signed [AW+1:0] skew,
    output logic                 ovf
);

    logic          pop;
    logic          push_a, push_b;
    logic          drop_a, drop_b;
    logic          full_a, full_b;
    logic          empty_a, empty_b;
    logic [DW-1:0] dout_a, dout_b;
    logic [AW:0]   cnt_a, cnt_b;
    logic [AW:0]   nxt_a, nxt_b;
    logic signed [AW+1:0] skew_nxt;

    // Both buffers pop together; an entry written this edge is never popped
    // because emptiness is judged from the registered counts.
    assign pop    = !empty_a && !empty_b && !clr;
    assign push_a = a_valid && !clr && (!full_a || pop);
    assign push_b = b_valid && !clr && (!full_b || pop);
    assign drop_a = a_valid && !clr && full_a && !pop;
    assign drop_b = b_valid && !clr && full_b && !pop;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo_a (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .push  (push_a),
        .pop   (pop),
        .din   (a_data),
        .dout  (dout_a),
        .count (cnt_a),
        .full  (full_a),
        .empty (empty_a)
    );

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo_b (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .push  (push_b),
        .pop   (pop),
        .din   (b_data),
        .dout  (dout_b),
        .count (cnt_b),
        .full  (full_b),
        .empty (empty_b)
    );

    // Post-edge occupancies, so skew tracks the counts it is registered with.
    always_comb begin
        nxt_a = cnt_a;
        nxt_b = cnt_b;
        if (clr) begin
            nxt_a = '0;
            nxt_b = '0;
        end else begin
            if (push_a && !pop) begin
                nxt_a = cnt_a + 1'b1;
            end else if (!push_a && pop) begin
                nxt_a = cnt_a - 1'b1;
            end
            if (push_b && !pop) begin
                nxt_b = cnt_b + 1'b1;
            end else if (!push_b && pop) begin
                nxt_b = cnt_b - 1'b1;
            end
        end
        skew_nxt = $signed({1'b0, nxt_a}) - $signed({1'b0, nxt_b});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            skew      <= '0;
            ovf       <= 1'b0;
        end else begin
            skew <= skew_nxt;
            if (clr) begin
                out_valid <= 1'b0;
                ovf       <= 1'b0;
            end else begin
                out_valid <= pop;
                if (pop) begin
                    out_a <= $signed(dout_a);
                    out_b <= $signed(dout_b);
                end
                if (drop_a || drop_b) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_skew_align.sv
module tb_skew_align;
    import skew_align_pkg::*;

    localparam int DW    = SA_DW;
    localparam int DEPTH = SA_DEPTH;
    localparam int AW    = SA_AW;

    logic                 clk;
    logic                 reset;
    logic                 clr;
    logic                 a_valid;
    logic signed [DW-1:0] a_data;
    logic                 b_valid;
    logic signed [DW-1:0] b_data;
    logic                 out_valid;
    logic signed [DW-1:0] out_a;
    logic signed [DW-1:0] out_b;
    logic signed [AW+1:0] skew;
    logic                 ovf;

    int total = 0;
    int bad   = 0;

    skew_align #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .out_valid (out_valid),
        .out_a     (out_a),
        .out_b     (out_b),
        .skew      (skew),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    // Reference model: two queues of waiting samples plus the output state.
    sample_t qa[$];
    sample_t qb[$];
    logic    m_valid;
    sample_t m_a, m_b;
    int      m_skew;
    logic    m_ovf;

    task automatic model_clear();
        qa.delete();
        qb.delete();
        m_valid = 1'b0;
        m_a     = '0;
        m_b     = '0;
        m_skew  = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge(input logic av, input sample_t ad,
                              input logic bv, input sample_t bd, input logic c);
        if (c) begin
            qa.delete();
            qb.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            if (qa.size() != 0 && qb.size() != 0) begin
                m_a     = qa.pop_front();
                m_b     = qb.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            // Room is judged after the pop, matching "count<DEPTH or pop".
            if (av) begin
                if (qa.size() < DEPTH) qa.push_back(ad);
                else                   m_ovf = 1'b1;
            end
            if (bv) begin
                if (qb.size() < DEPTH) qb.push_back(bd);
                else                   m_ovf = 1'b1;
            end
        end
        m_skew = qa.size() - qb.size();
    endtask

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_valid"}, out_valid,      m_valid);
        chk({tag, "_a"},     out_a,          m_a);
        chk({tag, "_b"},     out_b,          m_b);
        chk({tag, "_skew"},  skew,           m_skew);
        chk({tag, "_ovf"},   ovf,            m_ovf);
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1ns later.
    task automatic step(input logic av, input sample_t ad,
                        input logic bv, input sample_t bd, input logic c);
        a_valid = av; a_data = ad;
        b_valid = bv; b_data = bd;
        clr     = c;
        @(posedge clk);
        model_edge(av, ad, bv, bd, c);
        #1;
        chk_model("model");
        a_valid = 1'b0;
        b_valid = 1'b0;
        clr     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // Held reset with random activity on the inputs: outputs must stay zero.
    task automatic do_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'($urandom); a_data = sample_t'($urandom);
            b_valid = 1'($urandom); b_data = sample_t'($urandom);
            clr     = 1'($urandom);
            @(posedge clk);
            #1;
            chk("rst_valid", out_valid, 0);
            chk("rst_a",     out_a,     0);
            chk("rst_b",     out_b,     0);
            chk("rst_skew",  skew,      0);
            chk("rst_ovf",   ovf,       0);
        end
        a_valid = 1'b0; b_valid = 1'b0; clr = 1'b0;
        a_data  = '0;   b_data  = '0;
        model_clear();
        reset = 1'b1;
    endtask

    typedef struct {
        logic    av;
        sample_t ad;
        logic    bv;
        sample_t bd;
        logic    c;
        logic    ev;
        sample_t ea;
        sample_t eb;
        int      es;
        logic    eo;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int npairs;
        int pa, pb, pc;

        // Hand-computed sequence from a fresh reset; expectations are the
        // outputs seen after each edge.
        tbl[0] = '{1'b1, 10, 1'b0, 0,  1'b0, 1'b0, 0,  0,  1, 1'b0};
        tbl[1] = '{1'b1, 11, 1'b1, 20, 1'b0, 1'b0, 0,  0,  1, 1'b0};
        tbl[2] = '{1'b0, 0,  1'b1, 21, 1'b0, 1'b1, 10, 20, 0, 1'b0};
        tbl[3] = '{1'b0, 0,  1'b0, 0,  1'b0, 1'b1, 11, 21, 0, 1'b0};
        tbl[4] = '{1'b0, 0,  1'b0, 0,  1'b0, 1'b0, 11, 21, 0, 1'b0};
        tbl[5] = '{1'b0, 0,  1'b1, -5, 1'b0, 1'b0, 11, 21, -1, 1'b0};
        tbl[6] = '{1'b0, 0,  1'b1, -6, 1'b0, 1'b0, 11, 21, -2, 1'b0};
        tbl[7] = '{1'b1, 7,  1'b0, 0,  1'b0, 1'b0, 11, 21, -1, 1'b0};
        tbl[8] = '{1'b0, 0,  1'b0, 0,  1'b0, 1'b1, 7,  -5, -1, 1'b0};
        tbl[9] = '{1'b1, 9,  1'b0, 0,  1'b1, 1'b0, 7,  -5, 0, 1'b0};

        reset = 1'b1; clr = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
        model_clear();
        #2;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd, tbl[i].c);
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_a", i),     out_a,     tbl[i].ea);
            chk($sformatf("tbl%0d_b", i),     out_b,     tbl[i].eb);
            chk($sformatf("tbl%0d_skew", i),  skew,      tbl[i].es);
            chk($sformatf("tbl%0d_ovf", i),   ovf,       tbl[i].eo);
        end

        // B lags A by four cycles.
        do_reset();
        for (int t = 0; t < 20; t++) begin
            step(1'b1, sample_t'(t + 1), t >= 4, sample_t'(t - 3), 1'b0);
            chk("skew4_valid", out_valid, t >= 5);
            if (t >= 5) begin
                chk("skew4_a", out_a, t - 4);
                chk("skew4_b", out_b, t - 4);
            end
            if (t >= 3) chk("skew4_skew", skew, 4);
        end
        idle(6);

        // Overflow: ninth A sample is dropped, then B drains eight pairs.
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, sample_t'(k), 1'b0, '0, 1'b0);
            chk("ovf_flag", ovf, k == 9);
        end
        npairs = 0;
        for (int k = 1; k <= 11; k++) begin
            step(1'b0, '0, k <= 8, sample_t'(k), 1'b0);
            if (out_valid) begin
                npairs++;
                chk("ovf_pair_a", out_a, npairs);
                chk("ovf_pair_b", out_b, npairs);
            end
            chk("ovf_sticky", ovf, 1);
        end
        chk("ovf_pair_count", npairs, 8);

        // Full A keeps accepting while pairs drain every cycle.
        do_reset();
        for (int k = 1; k <= 8; k++) step(1'b1, sample_t'(k), 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1, 1, 1'b0);
        chk("full_skew_start", skew, 7);
        for (int k = 0; k < 15; k++) begin
            step(1'b1, sample_t'(9 + k), 1'b1, sample_t'(2 + k), 1'b0);
            chk("full_skew", skew, 7);
            chk("full_ovf", ovf, 0);
            chk("full_valid", out_valid, 1);
            chk("full_a", out_a, 1 + k);
        end
        idle(10);

        // clr: A holds 5, B empty, ovf set; the A sample offered with clr is lost.
        do_reset();
        for (int k = 1; k <= 9; k++) step(1'b1, sample_t'(k), 1'b0, '0, 1'b0);
        for (int k = 1; k <= 3; k++) step(1'b0, '0, 1'b1, sample_t'(k), 1'b0);
        idle(1);
        chk("clr_pre_skew", skew, 5);
        chk("clr_pre_ovf", ovf, 1);
        step(1'b1, 99, 1'b0, '0, 1'b1);
        chk("clr_skew", skew, 0);
        chk("clr_ovf", ovf, 0);
        chk("clr_valid", out_valid, 0);
        step(1'b0, '0, 1'b1, 50, 1'b0);
        chk("clr_b_only_skew", skew, -1);
        idle(1);
        chk("clr_lost", out_valid, 0);

        // Extreme values pass bit-exact.
        do_reset();
        step(1'b1, -25'sd16777216, 1'b1, 25'sd16777215, 1'b0);
        idle(1);
        chk("ext_valid", out_valid, 1);
        chk("ext_a", out_a, -64'sd16777216);
        chk("ext_b", out_b, 64'sd16777215);

        // Asynchronous reset in the middle of a burst.
        for (int k = 0; k < 6; k++)
            step(1'b1, sample_t'(100 + k), k >= 2, sample_t'(200 + k), 1'b0);
        chk("burst_valid", out_valid, 1);
        reset = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_a",     out_a,     0);
        chk("arst_b",     out_b,     0);
        chk("arst_skew",  skew,      0);
        chk("arst_ovf",   ovf,       0);
        model_clear();
        #2;
        reset = 1'b1;
        for (int k = 0; k < 4; k++)
            step(1'b1, sample_t'(300 + k), 1'b1, sample_t'(-300 - k), 1'b0);
        chk("restart_a", out_a, 302);
        chk("restart_b", out_b, -302);

        // Randomised phases: balanced, A-heavy, B-heavy, balanced with clr.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            case (i / 100)
                0:       begin pa = 50; pb = 50; pc = 0;  end
                1:       begin pa = 90; pb = 30; pc = 0;  end
                2:       begin pa = 30; pb = 90; pc = 0;  end
                default: begin pa = 60; pb = 60; pc = 3;  end
            endcase
            step($urandom_range(0, 99) < pa, sample_t'($urandom),
                 $urandom_range(0, 99) < pb, sample_t'($urandom),
                 $urandom_range(0, 99) < pc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
